// File: rtl/freecell_move_sequencer_pkg.sv
// Shared move codes, sequencer state and ASCII move decode for the freecell move sequencer.
// Optional build macro: FREECELL_ASCII_EN (16-bit ASCII move input instead of 8-bit raw codes).
package freecell_pkg;

  localparam logic [3:0] COL1   = 4'd0;
  localparam logic [3:0] COL2   = 4'd1;
  localparam logic [3:0] COL3   = 4'd2;
  localparam logic [3:0] COL4   = 4'd3;
  localparam logic [3:0] COL5   = 4'd4;
  localparam logic [3:0] COL6   = 4'd5;
  localparam logic [3:0] COL7   = 4'd6;
  localparam logic [3:0] COL8   = 4'd7;
  localparam logic [3:0] FREE_A = 4'd8;
  localparam logic [3:0] FREE_B = 4'd9;
  localparam logic [3:0] FREE_C = 4'd10;
  localparam logic [3:0] FREE_D = 4'd11;
  localparam logic [3:0] HOME   = 4'd12;

`ifdef FREECELL_ASCII_EN
  localparam int unsigned MOVE_W = 16;
`else
  localparam int unsigned MOVE_W = 8;
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, WON} state_e;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
  } move_t;

  localparam move_t NOP_MOVE = '{src: HOME, dst: HOME};

  // Map one ASCII character to {ok, code}; unknown characters return ok=0.
  function automatic logic [4:0] decode_char(input logic [7:0] c);
    if (c >= 8'h31 && c <= 8'h38) return {1'b1, 4'(c - 8'h31)};
    if (c >= 8'h61 && c <= 8'h64) return {1'b1, FREE_A + 4'(c - 8'h61)};
    if (c == 8'h68)               return {1'b1, HOME};
    return {1'b0, HOME};
  endfunction

  // Decode an ASCII {src_char, dst_char} pair; any bad character yields the no-op move.
  function automatic move_t decode_move(input logic [15:0] m);
    logic [4:0] s;
    logic [4:0] d;
    s = decode_char(m[15:8]);
    d = decode_char(m[7:0]);
    if (s[4] && d[4]) return '{src: s[3:0], dst: d[3:0]};
    return NOP_MOVE;
  endfunction

endpackage

// File: rtl/freecell_move_sequencer_if.sv
// Move source / player-side bus of the freecell move sequencer.
interface freecell_move_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  import freecell_pkg::*;

  logic              start;
  logic              pause;
  logic              in_valid;
  logic [MOVE_W-1:0] in_move;
  logic              in_ready;
  logic              win;
  logic [3:0]        source;
  logic [3:0]        dest;
  logic              move_valid;
  logic [CNT_W-1:0]  move_count;
  logic              busy;
  logic              won;

  modport master (
    output start, pause, in_valid, in_move, win,
    input  in_ready, source, dest, move_valid, move_count, busy, won
  );

  modport slave (
    input  start, pause, in_valid, in_move, win,
    output in_ready, source, dest, move_valid, move_count, busy, won
  );
endinterface

// File: rtl/freecell_move_fifo.sv
// Single-clock move FIFO with full/empty flags and a synchronous flush.
module freecell_move_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; flush empties the FIFO ahead of any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/freecell_move_sequencer.sv
// Buffers moves and issues at most one {source,dest} per clock to the freecell player.
// Optional build macro: FREECELL_ASCII_EN decodes ASCII move pairs at push time.
module freecell_move_sequencer
  import freecell_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input logic                      clock,
  input logic                      reset,
  freecell_move_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             fifo_full, fifo_empty;
  logic             push_c, pop_c, head_real_c;
  move_t            fifo_head, push_move;
  logic [3:0]       source_q, source_d;
  logic [3:0]       dest_q, dest_d;
  logic             move_valid_q, move_valid_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;
  logic             busy_q, busy_d;
  logic             won_q, won_d;

`ifdef FREECELL_ASCII_EN
  assign push_move   = decode_move(bus.in_move);
  assign head_real_c = (fifo_head != NOP_MOVE);
`else
  assign push_move   = move_t'(bus.in_move);
  assign head_real_c = 1'b1;
`endif

  assign bus.in_ready = !fifo_full && (state_q != WON);
  assign push_c       = bus.in_valid && bus.in_ready;

  freecell_move_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (bus.win),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (push_move),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; win overrides everything and only reset leaves WON.
  always_comb begin
    state_d = state_q;
    if (bus.win) begin
      state_d = WON;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = RUN;
        RUN:     if (bus.pause) state_d = PAUSE;
        PAUSE:   if (bus.start && !bus.pause) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Pop decision and next output values; a win cancels a pop in the same cycle.
  always_comb begin
    pop_c        = 1'b0;
    source_d     = HOME;
    dest_d       = HOME;
    move_valid_d = 1'b0;
    move_count_d = move_count_q;
    busy_d       = (state_d == RUN) || (state_d == PAUSE);
    won_d        = won_q || bus.win;
    if (!bus.win && (state_q == RUN) && !bus.pause && !fifo_empty) begin
      pop_c    = 1'b1;
      source_d = fifo_head.src;
      dest_d   = fifo_head.dst;
      if (head_real_c) begin
        move_valid_d = 1'b1;
        if (move_count_q != CNT_MAX) move_count_d = move_count_q + CNT_W'(1);
      end
    end
  end

  // Registered player-facing outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      source_q     <= HOME;
      dest_q       <= HOME;
      move_valid_q <= 1'b0;
      move_count_q <= '0;
      busy_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      source_q     <= source_d;
      dest_q       <= dest_d;
      move_valid_q <= move_valid_d;
      move_count_q <= move_count_d;
      busy_q       <= busy_d;
      won_q        <= won_d;
    end
  end

  assign bus.source     = source_q;
  assign bus.dest       = dest_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_count = move_count_q;
  assign bus.busy       = busy_q;
  assign bus.won        = won_q;
endmodule

// File: tb/tb_freecell_move_sequencer.sv
// Scoreboard bench for freecell_move_sequencer: queue-based reference model plus monitor.
module tb_freecell_move_sequencer;
  import freecell_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_WON = 3;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  freecell_move_sequencer_if #(.CNT_W(CNT_W)) bus ();

  freecell_move_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue, plus what the outputs must show after the edge.
  logic [MOVE_W-1:0] mq [$];
  logic [7:0]        exp_q [$];
  int                m_st;
  bit                m_valid;
  int                m_cnt;
  bit                m_won;
  bit                m_pushed;
  string             cs = "12345678abcdh";
  string             rnd_chars = "12345678abcdhx9z";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Position in "12345678abcdh" equals the player code.
  function automatic int code_of(input logic [7:0] c);
    for (int i = 0; i < 13; i++) if (cs[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [MOVE_W-1:0] mv(input int s, input int d);
`ifdef FREECELL_ASCII_EN
    return {cs[s], cs[d]};
`else
    return {4'(s), 4'(d)};
`endif
  endfunction

  function automatic logic [MOVE_W-1:0] rnd_move();
`ifdef FREECELL_ASCII_EN
    return {rnd_chars[$urandom_range(0, 15)], rnd_chars[$urandom_range(0, 15)]};
`else
    return MOVE_W'($urandom_range(0, 255));
`endif
  endfunction

  task automatic model_issue(input logic [MOVE_W-1:0] e);
`ifdef FREECELL_ASCII_EN
    int s;
    int d;
    s = code_of(e[15:8]);
    d = code_of(e[7:0]);
    if (s < 0 || d < 0 || (s == 12 && d == 12)) return;
    exp_q.push_back({4'(s), 4'(d)});
`else
    exp_q.push_back(e[7:0]);
`endif
    m_valid = 1'b1;
    if (m_cnt < CNT_TOP) m_cnt++;
  endtask

  task automatic model_step();
    bit rdy;
    m_pushed = 1'b0;
    m_valid  = 1'b0;
    if (reset) begin
      mq.delete();
      m_st  = M_IDLE;
      m_cnt = 0;
      m_won = 1'b0;
      return;
    end
    rdy = (mq.size() < DEPTH) && (m_st != M_WON);
    if (bus.win) begin
      mq.delete();
      m_st  = M_WON;
      m_won = 1'b1;
      return;
    end
    if (m_st == M_RUN && !bus.pause && mq.size() > 0) model_issue(mq.pop_front());
    if (bus.in_valid && rdy) begin
      mq.push_back(bus.in_move);
      m_pushed = 1'b1;
    end
    case (m_st)
      M_IDLE:  if (bus.start) m_st = M_RUN;
      M_RUN:   if (bus.pause) m_st = M_PAUSE;
      M_PAUSE: if (bus.start && !bus.pause) m_st = M_RUN;
      default: ;
    endcase
  endtask

  task automatic step(input bit v, input logic [MOVE_W-1:0] m, input bit st, input bit pa,
                      input bit w, input bit rs);
    @(negedge clk);
    reset        = rs;
    bus.in_valid = v;
    bus.in_move  = m;
    bus.start    = st;
    bus.pause    = pa;
    bus.win      = w;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [MOVE_W-1:0] m);
    step(1'b1, m, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every cycle, popping the scoreboard whenever the DUT issues a move.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      check("move_valid", bus.move_valid, m_valid);
      if (bus.move_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_move: got %0h expected none at %0t", {bus.source, bus.dest}, $time);
        end else begin
          e = exp_q.pop_front();
          check("move", {bus.source, bus.dest}, e);
        end
      end else begin
        check("nop", {bus.source, bus.dest}, 8'hCC);
      end
      check("move_count", bus.move_count, m_cnt);
      check("busy", bus.busy, (m_st == M_RUN) || (m_st == M_PAUSE));
      check("won", bus.won, m_won);
      check("in_ready", bus.in_ready, (mq.size() < DEPTH) && (m_st != M_WON));
    end
  end

  initial begin
    logic [MOVE_W-1:0] held [17];
    int idx;
    bit pa;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_move  = '0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.win      = 1'b0;
    model_step();

    // Reset then idle: NOP, nothing counted.
    do_reset();
    idle(3);
    check("idle_source", bus.source, 4'd12);
    check("idle_count", bus.move_count, 0);

    // Three moves queued in IDLE, then start.
    push(mv(0, 12));
    push(mv(0, 12));
    push(mv(1, 12));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("count_after_3", bus.move_count, 3);

    // Fill to DEPTH, hold a 17th offer, then drain.
    do_reset();
    for (int i = 0; i < 17; i++) held[i] = mv(i % 12, (i * 5) % 13);
    idx = 0;
    for (int c = 0; c < 45; c++) begin
      step(idx < 17, held[idx < 17 ? idx : 0], c == 20, 1'b0, 1'b0, 1'b0);
      if (c == 19) check("full_in_ready", bus.in_ready, 1'b0);
      if (m_pushed) idx++;
    end
    check("count_after_17", bus.move_count, 17);

    // Pause after two issues, resume with start.
    do_reset();
    for (int i = 0; i < 5; i++) push(mv(i + 2, i + 8));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("paused_count", bus.move_count, 2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("count_after_pause", bus.move_count, 5);

    // Win with moves queued: flush, sticky won, start ignored.
    do_reset();
    for (int i = 0; i < 4; i++) push(mv(i, 12));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("won_sticky", bus.won, 1'b1);
    check("won_in_ready", bus.in_ready, 1'b0);

    // Win in a cycle that would otherwise pop.
    do_reset();
    push(mv(3, 4));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("win_pop_count", bus.move_count, 0);

`ifdef FREECELL_ASCII_EN
    do_reset();
    push(16'h3437);
    push(16'h6137);
    push(16'h7835);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("ascii_count", bus.move_count, 2);
`endif

    // Randomised traffic with occasional pause, start, win and reset.
    do_reset();
    pa = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 11) == 0) pa = ~pa;
      step($urandom_range(0, 2) != 0, rnd_move(), $urandom_range(0, 9) == 0, pa,
           $urandom_range(0, 299) == 0, $urandom_range(0, 119) == 0);
    end
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
